// File: rtl/toast_malu_sequencer_pkg.sv
// Shared definitions for the MALU issue/completion sequencer: FSM encoding,
// status bit positions and the custom opcode that routes instructions here.
package toast_malu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_ERROR = 3'd4
   } malu_state_e;

   localparam int MALU_ST_BUSY = 0;
   localparam int MALU_ST_FULL = 1;
   localparam int MALU_ST_ERR  = 2;

   localparam logic [6:0] OPCODE_MCUSTOM = 7'b0001011;

endpackage

// File: rtl/toast_malu_cmd_fifo.sv
// Command queue: push is visible at the head the next cycle; pushes while
// full and pops while empty are ignored, clr_i empties the queue at once.
module toast_malu_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    resetn_i,
   input  logic                    clr_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_dat_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        pop_dat_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign push_ok   = push_i && !full_o;
   assign pop_ok    = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         // Pointers wrap naturally because DEPTH is a power of two.
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/toast_malu_sequencer.sv
// Queues custom ALU commands and issues them one at a time (ID pulse to cmd_valid: 2 cycles);
// cmd_valid holds until ready, wb_req holds until grant, overflowing enqueues are dropped and flagged.
module toast_malu_sequencer
   import toast_malu_sequencer_pkg::*;
#(
   parameter int REG_DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int QDEPTH             = 4,
   parameter int FUNCT_WIDTH        = 10,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                          clk_i,
   input  logic                          resetn_i,
   input  logic                          ID_en_i,
   input  logic                          flush_i,
   input  logic [FUNCT_WIDTH-1:0]        ID_funct_i,
   input  logic [REG_DATA_WIDTH-1:0]     ID_rs1_data_i,
   input  logic [REG_DATA_WIDTH-1:0]     ID_rs2_data_i,
   input  logic [REGFILE_ADDR_WIDTH-1:0] ID_rd_addr_i,
   output logic [2:0]                    status_o,
   output logic                          malu_cmd_valid_o,
   input  logic                          malu_cmd_ready_i,
   output logic [FUNCT_WIDTH-1:0]        malu_funct_o,
   output logic [REG_DATA_WIDTH-1:0]     malu_op1_o,
   output logic [REG_DATA_WIDTH-1:0]     malu_op2_o,
   input  logic                          malu_done_i,
   input  logic [REG_DATA_WIDTH-1:0]     malu_result_i,
   output logic                          wb_req_o,
   input  logic                          wb_gnt_i,
   output logic [REGFILE_ADDR_WIDTH-1:0] wb_rd_addr_o,
   output logic [REG_DATA_WIDTH-1:0]     wb_data_o,
   input  logic                          err_clr_i
);

   localparam int CMD_W = FUNCT_WIDTH + 2*REG_DATA_WIDTH + REGFILE_ADDR_WIDTH;
   localparam int CW    = $clog2(QDEPTH) + 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   malu_state_e                   state_q, state_d;
   logic [TW-1:0]                 tmo_q, tmo_d;
   logic                          err_q, err_d;
   logic [REGFILE_ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [REG_DATA_WIDTH-1:0]     res_q, res_d;

   logic [CMD_W-1:0]              fifo_head;
   logic [CW-1:0]                 fifo_cnt;
   logic                          fifo_full, fifo_empty;
   logic                          fifo_push, fifo_pop, fifo_clr;
   logic                          enq_req, overflow;

   logic [FUNCT_WIDTH-1:0]        head_funct;
   logic [REG_DATA_WIDTH-1:0]     head_op1, head_op2;
   logic [REGFILE_ADDR_WIDTH-1:0] head_rd;

   assign {head_funct, head_op1, head_op2, head_rd} = fifo_head;

   // The queue is frozen while in ERROR until software clears it.
   assign enq_req   = ID_en_i && !flush_i && (state_q != ST_ERROR);
   assign fifo_push = enq_req && !fifo_full;
   assign overflow  = enq_req && fifo_full;
   assign fifo_pop  = (state_q == ST_ISSUE) && malu_cmd_ready_i;
   assign fifo_clr  = (state_q == ST_ERROR) && err_clr_i;

   toast_malu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (QDEPTH)
   ) u_cmd_fifo (
      .clk_i      (clk_i),
      .resetn_i   (resetn_i),
      .clr_i      (fifo_clr),
      .push_i     (fifo_push),
      .push_dat_i ({ID_funct_i, ID_rs1_data_i, ID_rs2_data_i, ID_rd_addr_i}),
      .pop_i      (fifo_pop),
      .pop_dat_o  (fifo_head),
      .count_o    (fifo_cnt),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      rd_d    = rd_q;
      res_d   = res_q;
      if (err_clr_i) err_d = 1'b0;
      if (overflow)  err_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (malu_cmd_ready_i) begin
               rd_d    = head_rd;
               tmo_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A completion arriving on the last allowed cycle still counts.
            if (malu_done_i) begin
               res_d = malu_result_i;
               if (rd_q != '0)       state_d = ST_WB;
               else if (!fifo_empty) state_d = ST_ISSUE;
               else                  state_d = ST_IDLE;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_ERROR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_WB: begin
            if (wb_gnt_i) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
         end
         ST_ERROR: begin
            if (err_clr_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      status_o               = '0;
      status_o[MALU_ST_BUSY] = !fifo_empty || (state_q != ST_IDLE);
      status_o[MALU_ST_FULL] = (fifo_cnt == CW'(QDEPTH));
      status_o[MALU_ST_ERR]  = err_q;
   end

   // Payload outputs are gated so that they read zero outside their phase.
   assign malu_cmd_valid_o = (state_q == ST_ISSUE);
   assign malu_funct_o     = malu_cmd_valid_o ? head_funct : '0;
   assign malu_op1_o       = malu_cmd_valid_o ? head_op1   : '0;
   assign malu_op2_o       = malu_cmd_valid_o ? head_op2   : '0;
   assign wb_req_o         = (state_q == ST_WB);
   assign wb_rd_addr_o     = wb_req_o ? rd_q  : '0;
   assign wb_data_o        = wb_req_o ? res_q : '0;

endmodule

// File: tb/tb_toast_malu_sequencer.sv
// Directed bench for the MALU sequencer; a negedge monitor checks every command
// handshake and writeback grant against queues filled when stimulus is issued.
module tb_toast_malu_sequencer;

   typedef struct packed {
      logic [9:0]  funct;
      logic [31:0] op1;
      logic [31:0] op2;
   } cmd_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic        clk_i = 1'b0;
   logic        resetn_i;
   logic        ID_en_i, flush_i;
   logic [9:0]  ID_funct_i;
   logic [31:0] ID_rs1_data_i, ID_rs2_data_i;
   logic [4:0]  ID_rd_addr_i;
   logic [2:0]  status_o;
   logic        malu_cmd_valid_o, malu_cmd_ready_i;
   logic [9:0]  malu_funct_o;
   logic [31:0] malu_op1_o, malu_op2_o;
   logic        malu_done_i;
   logic [31:0] malu_result_i;
   logic        wb_req_o, wb_gnt_i;
   logic [4:0]  wb_rd_addr_o;
   logic [31:0] wb_data_o;
   logic        err_clr_i;

   int   n_cmp = 0;
   int   n_bad = 0;
   cmd_t exp_cmd[$];
   wb_t  exp_wb[$];
   logic cmd_hold;
   cmd_t cmd_prev;
   logic wb_hold;
   wb_t  wb_prev;

   always #5 clk_i = ~clk_i;

   toast_malu_sequencer dut (
      .clk_i            (clk_i),
      .resetn_i         (resetn_i),
      .ID_en_i          (ID_en_i),
      .flush_i          (flush_i),
      .ID_funct_i       (ID_funct_i),
      .ID_rs1_data_i    (ID_rs1_data_i),
      .ID_rs2_data_i    (ID_rs2_data_i),
      .ID_rd_addr_i     (ID_rd_addr_i),
      .status_o         (status_o),
      .malu_cmd_valid_o (malu_cmd_valid_o),
      .malu_cmd_ready_i (malu_cmd_ready_i),
      .malu_funct_o     (malu_funct_o),
      .malu_op1_o       (malu_op1_o),
      .malu_op2_o       (malu_op2_o),
      .malu_done_i      (malu_done_i),
      .malu_result_i    (malu_result_i),
      .wb_req_o         (wb_req_o),
      .wb_gnt_i         (wb_gnt_i),
      .wb_rd_addr_o     (wb_rd_addr_o),
      .wb_data_o        (wb_data_o),
      .err_clr_i        (err_clr_i)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic enq(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
      ID_en_i = 1'b1; ID_funct_i = f; ID_rs1_data_i = a; ID_rs2_data_i = b; ID_rd_addr_i = rd;
      tick();
      ID_en_i = 1'b0;
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!malu_cmd_valid_o && n < max) begin
         tick();
         n++;
      end
      if (!malu_cmd_valid_o) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_valid: cmd_valid still 0 after %0d cycles, required 1", max);
      end
   endtask

   task automatic wait_wb(input int max);
      int n;
      n = 0;
      while (!wb_req_o && n < max) begin
         tick();
         n++;
      end
      if (!wb_req_o) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_wb: wb_req still 0 after %0d cycles, required 1", max);
      end
   endtask

   task automatic run_op(input logic [31:0] res, input bit has_wb);
      wait_valid(20);
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      tick();
      malu_done_i = 1'b1; malu_result_i = res;
      tick();
      malu_done_i = 1'b0;
      if (has_wb) begin
         wait_wb(5);
         wb_gnt_i = 1'b1;
         tick();
         wb_gnt_i = 1'b0;
      end else begin
         chk("rd0_no_wb_req", 32'(wb_req_o), 0);
      end
   endtask

   // Scoreboard monitor: handshakes, stability while stalled.
   always @(negedge clk_i) begin
      if (resetn_i) begin
         if (cmd_hold) begin
            chk("cmd_hold_valid", 32'(malu_cmd_valid_o), 1);
            chk("cmd_hold_funct", 32'(malu_funct_o), 32'(cmd_prev.funct));
            chk("cmd_hold_op1", malu_op1_o, cmd_prev.op1);
         end
         if (wb_hold) begin
            chk("wb_hold_req", 32'(wb_req_o), 1);
            chk("wb_hold_data", wb_data_o, wb_prev.data);
         end
         if (malu_cmd_valid_o && malu_cmd_ready_i) begin
            if (exp_cmd.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL cmd_unexpected: got funct %0h op1 %0h, required no command",
                        malu_funct_o, malu_op1_o);
            end else begin
               cmd_t e;
               e = exp_cmd.pop_front();
               chk("cmd_funct", 32'(malu_funct_o), 32'(e.funct));
               chk("cmd_op1", malu_op1_o, e.op1);
               chk("cmd_op2", malu_op2_o, e.op2);
            end
         end
         if (wb_req_o && wb_gnt_i) begin
            if (exp_wb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL wb_unexpected: got rd %0d data %0h, required no writeback",
                        wb_rd_addr_o, wb_data_o);
            end else begin
               wb_t w;
               w = exp_wb.pop_front();
               chk("wb_rd_addr", 32'(wb_rd_addr_o), 32'(w.rd));
               chk("wb_data", wb_data_o, w.data);
            end
         end
      end
      cmd_hold = resetn_i && malu_cmd_valid_o && !malu_cmd_ready_i;
      cmd_prev = '{malu_funct_o, malu_op1_o, malu_op2_o};
      wb_hold  = resetn_i && wb_req_o && !wb_gnt_i;
      wb_prev  = '{wb_rd_addr_o, wb_data_o};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_hold = 1'b0; wb_hold = 1'b0;
      cmd_prev = '0; wb_prev = '0;
      resetn_i = 1'b0; ID_en_i = 1'b0; flush_i = 1'b0; ID_funct_i = '0;
      ID_rs1_data_i = '0; ID_rs2_data_i = '0; ID_rd_addr_i = '0;
      malu_cmd_ready_i = 1'b0; malu_done_i = 1'b0; malu_result_i = '0;
      wb_gnt_i = 1'b0; err_clr_i = 1'b0;
      repeat (3) tick();
      chk("reset_status", 32'(status_o), 0);
      chk("reset_valid_req", 32'({malu_cmd_valid_o, wb_req_o}), 0);
      chk("reset_op1", malu_op1_o, 0);
      chk("reset_wb_data", wb_data_o, 0);
      resetn_i = 1'b1;
      tick();

      // Single op: enqueue in cycle 0, valid in cycle 2, wb_req in cycle 7.
      malu_cmd_ready_i = 1'b1;
      exp_cmd.push_back('{10'h001, 32'd5, 32'd7});
      exp_wb.push_back('{5'd3, 32'd35});
      enq(10'h001, 32'd5, 32'd7, 5'd3);
      chk("single_c1_valid", 32'(malu_cmd_valid_o), 0);
      chk("single_c1_status", 32'(status_o), 32'h1);
      tick();
      chk("single_c2_valid", 32'(malu_cmd_valid_o), 1);
      repeat (4) tick();
      malu_cmd_ready_i = 1'b0;
      malu_done_i = 1'b1; malu_result_i = 32'd35;
      tick();
      malu_done_i = 1'b0;
      chk("single_c7_wb_req", 32'(wb_req_o), 1);
      wb_gnt_i = 1'b1;
      tick();
      wb_gnt_i = 1'b0;
      chk("single_c8_wb_req", 32'(wb_req_o), 0);
      chk("single_c8_status", 32'(status_o), 0);

      // Backpressure: ready withheld for 5 cycles while valid is up.
      exp_cmd.push_back('{10'h002, 32'h10, 32'h20});
      exp_wb.push_back('{5'd4, 32'hAB});
      enq(10'h002, 32'h10, 32'h20, 5'd4);
      wait_valid(5);
      repeat (5) tick();
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      chk("bp_valid_after_pop", 32'(malu_cmd_valid_o), 0);
      chk("bp_status_wait", 32'(status_o), 32'h1);
      malu_done_i = 1'b1; malu_result_i = 32'hAB;
      tick();
      malu_done_i = 1'b0;
      wait_wb(3);
      repeat (2) tick();
      wb_gnt_i = 1'b1;
      tick();
      wb_gnt_i = 1'b0;
      tick();
      chk("bp_status_done", 32'(status_o), 0);

      // Fill while stalled, then overflow with a fifth command.
      exp_cmd.push_back('{10'h0A1, 32'd1, 32'd2});  exp_wb.push_back('{5'd1,  32'h101});
      exp_cmd.push_back('{10'h0B2, 32'd3, 32'd4});  exp_wb.push_back('{5'd2,  32'h202});
      exp_cmd.push_back('{10'h0C3, 32'd5, 32'd6});  exp_wb.push_back('{5'd5,  32'h303});
      exp_cmd.push_back('{10'h0D4, 32'd7, 32'd8});  exp_wb.push_back('{5'd12, 32'h404});
      enq(10'h0A1, 32'd1, 32'd2, 5'd1);  tick();
      enq(10'h0B2, 32'd3, 32'd4, 5'd2);  tick();
      enq(10'h0C3, 32'd5, 32'd6, 5'd5);
      chk("fill_3_status", 32'(status_o), 32'h1);
      tick();
      enq(10'h0D4, 32'd7, 32'd8, 5'd12);
      chk("fill_4_status", 32'(status_o), 32'h3);
      tick();
      enq(10'h3FF, 32'hDEAD, 32'hBEEF, 5'd13);
      chk("overflow_status", 32'(status_o), 32'h7);
      chk("overflow_head", 32'(malu_funct_o), 32'h0A1);
      run_op(32'h101, 1'b1);
      run_op(32'h202, 1'b1);
      run_op(32'h303, 1'b1);
      run_op(32'h404, 1'b1);
      tick();
      chk("drain_status", 32'(status_o), 32'h4);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("ovf_clr_status", 32'(status_o), 0);

      // rd=0 retires without writeback; rd=9 follows in order.
      exp_cmd.push_back('{10'h003, 32'd2, 32'd3});
      exp_cmd.push_back('{10'h004, 32'd6, 32'd7});
      exp_wb.push_back('{5'd9, 32'h99});
      enq(10'h003, 32'd2, 32'd3, 5'd0);
      enq(10'h004, 32'd6, 32'd7, 5'd9);
      run_op(32'h11, 1'b0);
      run_op(32'h99, 1'b1);
      tick();
      chk("rd0_status", 32'(status_o), 0);

      // Timeout with one entry queued behind the stuck command.
      exp_cmd.push_back('{10'h005, 32'd1, 32'd1});
      enq(10'h005, 32'd1, 32'd1, 5'd6);
      wait_valid(5);
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      enq(10'h006, 32'd2, 32'd2, 5'd7);
      repeat (1022) tick();
      chk("tmo_last_wait_status", 32'(status_o), 32'h1);
      tick();
      chk("tmo_error_status", 32'(status_o), 32'h5);
      chk("tmo_error_outs", 32'({malu_cmd_valid_o, wb_req_o}), 0);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("tmo_clr_status", 32'(status_o), 0);
      repeat (3) tick();
      chk("tmo_queue_empty_valid", 32'(malu_cmd_valid_o), 0);

      // Done on the final WAIT cycle beats the timeout.
      exp_cmd.push_back('{10'h007, 32'd3, 32'd3});
      exp_wb.push_back('{5'd8, 32'h77});
      enq(10'h007, 32'd3, 32'd3, 5'd8);
      wait_valid(5);
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      repeat (1023) tick();
      malu_done_i = 1'b1; malu_result_i = 32'h77;
      tick();
      malu_done_i = 1'b0;
      chk("tmo_edge_err", 32'(status_o[2]), 0);
      chk("tmo_edge_wb_req", 32'(wb_req_o), 1);
      wb_gnt_i = 1'b1;
      tick();
      wb_gnt_i = 1'b0;

      // Flush suppresses the coincident enqueue.
      ID_en_i = 1'b1; flush_i = 1'b1; ID_funct_i = 10'h0EE; ID_rd_addr_i = 5'd2;
      tick();
      ID_en_i = 1'b0; flush_i = 1'b0;
      chk("flush_status", 32'(status_o), 0);
      repeat (2) tick();
      chk("flush_no_valid", 32'(malu_cmd_valid_o), 0);

      // Reset during WAIT.
      exp_cmd.push_back('{10'h008, 32'd4, 32'd4});
      enq(10'h008, 32'd4, 32'd4, 5'd10);
      wait_valid(5);
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      tick();
      resetn_i = 1'b0;
      #1;
      chk("rst_wait_status", 32'(status_o), 0);
      chk("rst_wait_outs", 32'({malu_cmd_valid_o, wb_req_o}), 0);
      tick();
      resetn_i = 1'b1;
      malu_done_i = 1'b1; malu_result_i = 32'h66;
      tick();
      malu_done_i = 1'b0;
      repeat (2) tick();
      chk("rst_wait_no_wb", 32'(wb_req_o), 0);

      // Reset during WB.
      exp_cmd.push_back('{10'h009, 32'd5, 32'd5});
      enq(10'h009, 32'd5, 32'd5, 5'd11);
      wait_valid(5);
      malu_cmd_ready_i = 1'b1;
      tick();
      malu_cmd_ready_i = 1'b0;
      malu_done_i = 1'b1; malu_result_i = 32'h55;
      tick();
      malu_done_i = 1'b0;
      chk("rst_wb_pre_req", 32'(wb_req_o), 1);
      chk("rst_wb_pre_rd", 32'(wb_rd_addr_o), 11);
      resetn_i = 1'b0;
      #1;
      chk("rst_wb_req", 32'(wb_req_o), 0);
      chk("rst_wb_data", wb_data_o, 0);
      chk("rst_wb_rd", 32'(wb_rd_addr_o), 0);
      tick();
      resetn_i = 1'b1;
      repeat (3) tick();
      chk("rst_wb_after", 32'({wb_req_o, status_o}), 0);

      chk("sb_cmd_left", exp_cmd.size(), 0);
      chk("sb_wb_left", exp_wb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
